target_sync_ctrl: RTL and testbench
===================================

Name: target_sync_ctrl

Overview:
- Sequences the periodic hard copy of all weights from the online (policy) network weight memory into the target network weight memory.
- Counts completed training steps and starts a sync every SYNC_PERIOD steps or on a forced request.
- Issues one read request per cycle to the online net and forwards each returned weight as a write to the target net.
- Sits beside target_net in the DQN top level and holds off target-net feed-forward while a copy is in progress.

Parameters:
- DATA_WIDTH, 32, weight word width
- LAYER_WIDTH, 2, weight layer code width (1 = hidden 1, 2 = hidden 2, 3 = output)
- NUMBER_OF_INPUT_NODE, 2, input nodes
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, hidden layer 1 nodes (H1)
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, hidden layer 2 nodes (H2)
- NUMBER_OF_OUTPUT_NODE, 3, output nodes (OUT)
- SYNC_PERIOD, 100, training steps between automatic syncs (must be 1 or more)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_step_valid  in  1  one-cycle pulse per completed training step
- i_force_sync  in  1  one-cycle pulse requesting an immediate sync
- i_fw_busy  in  1  target-net feed-forward in progress
- o_src_rd_valid  out  1  read request to online net weight memory
- o_src_rd_layer  out  LAYER_WIDTH  read layer
- o_src_rd_addr  out  11  read address
- i_src_valid  in  1  read data valid (latency 1 or more, in order)
- i_src_layer  in  LAYER_WIDTH  returned layer
- i_src_addr  in  11  returned address
- i_src_weight  in  DATA_WIDTH  returned weight
- o_dst_wr_valid  out  1  write strobe to target net (rw select = 0)
- o_dst_layer  out  LAYER_WIDTH  write layer
- o_dst_addr  out  11  write address
- o_dst_weight  out  DATA_WIDTH  write data
- o_sync_busy  out  1  copy in progress; upstream must not start feed-forward
- o_sync_done  out  1  one-cycle pulse when the last weight has been written
- o_step_count  out  clog2(SYNC_PERIOD+1)  steps since last sync trigger

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and all counters and the pending flag are 0.
- Layer sizes:
  - L1 = H1*(IN+1)
  - L2 = H2*(H1+1)
  - L3 = OUT*(H2+1)
  - TOTAL = L1+L2+L3
  - With defaults: L1 = 96, L2 = 1056, L3 = 99, TOTAL = 1251.
- Step counter:
  - Increments on i_step_valid.
  - On i_step_valid while the count equals SYNC_PERIOD-1, it wraps to 0 and raises a trigger.
  - i_force_sync raises a trigger and clears the counter. This takes priority over a same-cycle step.
- Pending flag: any trigger sets it. It is cleared when the FSM leaves IDLE/WAIT_FW toward ISSUE. Multiple triggers collapse into one.
- FSM:
  - IDLE: if pending and !i_fw_busy, go to ISSUE; if pending and i_fw_busy, go to WAIT_FW.
  - WAIT_FW: go to ISSUE the first cycle i_fw_busy = 0.
  - ISSUE:
    - Assert o_src_rd_valid every cycle, starting at layer 1, address 0.
    - Address increments each cycle. At L1-1, L2-1 or L3-1 respectively it wraps to 0 and the layer increments.
    - After issuing layer 3, address L3-1, go to DRAIN.
  - DRAIN: wait until the received count equals TOTAL, then go to DONE.
  - DONE: o_sync_done = 1 for one cycle. Then go to ISSUE if pending and !i_fw_busy, to WAIT_FW if pending and busy, otherwise to IDLE.
- o_sync_busy = 1 in ISSUE, DRAIN and DONE, and also in WAIT_FW, to block new feed-forward starts.
- Write path:
  - Latency is 1 cycle: o_dst_* are registered copies of i_src_* whenever i_src_valid is 1 and the state is ISSUE or DRAIN.
  - Layer and address pass through unchanged.
  - i_src_valid outside ISSUE/DRAIN is ignored (no write, not counted).
- Received count increments on each accepted return. It is compared against TOTAL; the 11-bit address space covers the largest layer.
- A trigger arriving during ISSUE, DRAIN or DONE sets pending only, so exactly one further sync follows.
- i_fw_busy is sampled only in IDLE, WAIT_FW and DONE; it has no effect mid-copy.
- Reset mid-copy: the copy is abandoned, o_sync_done is not pulsed, and the target weights are a partial mix. Software re-forces a sync after reset.

Decomposition:
- Shared package:
  - layer code constants (LAYER_H1 = 1, LAYER_H2 = 2, LAYER_OUT = 3)
  - the weight address width of 11
  - functions computing L1/L2/L3/TOTAL from the node parameters
  - FSM state enum
- One natural sub-module, sync_step_counter: holds the step counter, force handling and pending flag.
- The address sequencer and FSM stay in the top.

Test Plan:
- Params IN=2, H1=4, H2=4, OUT=3 (TOTAL = 47), memory model latency 2:
  - i_force_sync -> 47 reads, layer/address sequence 1:0..11, 2:0..19, 3:0..14.
  - 47 writes with matching layer/address/data.
  - o_sync_done pulses once, 2 cycles after the last read + 1.
- SYNC_PERIOD = 5: 5 step pulses -> trigger on the 5th, o_step_count reads 0; 4 pulses -> no sync.
- i_fw_busy = 1 when triggered -> FSM in WAIT_FW, o_sync_busy = 1, no reads; busy drops -> first read next cycle.
- Force pulse plus 5 step pulses during ISSUE -> exactly one extra sync follows DONE, giving 94 total writes and 2 done pulses.
- Spurious i_src_valid in IDLE -> no o_dst_wr_valid; rst_n low after read 20 -> all outputs 0, no done pulse, next force restarts at layer 1, address 0.

Source files
------------

// File: rtl/target_sync_ctrl_pkg.sv
// Shared constants, layer-size helpers and FSM states for the online-to-target
// weight copy controller.
package target_sync_ctrl_pkg;

    localparam int WEIGHT_ADDR_WIDTH = 11;

    localparam int LAYER_H1  = 1;
    localparam int LAYER_H2  = 2;
    localparam int LAYER_OUT = 3;

    // Every layer holds one weight per (node, input) pair plus one bias per node.
    function automatic int layer1_size(input int n_in, input int n_h1);
        return n_h1 * (n_in + 1);
    endfunction

    function automatic int layer2_size(input int n_h1, input int n_h2);
        return n_h2 * (n_h1 + 1);
    endfunction

    function automatic int layer3_size(input int n_h2, input int n_out);
        return n_out * (n_h2 + 1);
    endfunction

    function automatic int total_weights(input int n_in, input int n_h1,
                                         input int n_h2, input int n_out);
        return layer1_size(n_in, n_h1) + layer2_size(n_h1, n_h2)
             + layer3_size(n_h2, n_out);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FW,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sync_state_t;

endpackage

// File: rtl/target_sync_ctrl_sync_step_counter.sv
// Training-step counter that raises sync triggers and remembers them in a
// single pending flag until the copy FSM consumes it.
module sync_step_counter #(
    parameter int SYNC_PERIOD = 100,
    parameter int CNT_WIDTH   = $clog2(SYNC_PERIOD + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_valid,
    input  logic                 force_sync,
    input  logic                 clear_pending,
    output logic [CNT_WIDTH-1:0] step_count,
    output logic                 pending
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(SYNC_PERIOD - 1);

    logic trigger;

    assign trigger = force_sync || (step_valid && (step_count == LAST_COUNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count <= '0;
        end else if (force_sync) begin
            step_count <= '0;
        end else if (step_valid) begin
            step_count <= (step_count == LAST_COUNT) ? '0 : step_count + 1'b1;
        end
    end

    // A trigger landing in the same cycle the FSM consumes the flag must survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (trigger) begin
            pending <= 1'b1;
        end else if (clear_pending) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/target_sync_ctrl.sv
// Copies every online-network weight into the target network, one read per
// cycle, every SYNC_PERIOD training steps or on a forced request.
module target_sync_ctrl
    import target_sync_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int SYNC_PERIOD                   = 100
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_step_valid,
    input  logic                                 i_force_sync,
    input  logic                                 i_fw_busy,
    output logic                                 o_src_rd_valid,
    output logic [LAYER_WIDTH-1:0]               o_src_rd_layer,
    output logic [WEIGHT_ADDR_WIDTH-1:0]         o_src_rd_addr,
    input  logic                                 i_src_valid,
    input  logic [LAYER_WIDTH-1:0]               i_src_layer,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]         i_src_addr,
    input  logic [DATA_WIDTH-1:0]                i_src_weight,
    output logic                                 o_dst_wr_valid,
    output logic [LAYER_WIDTH-1:0]               o_dst_layer,
    output logic [WEIGHT_ADDR_WIDTH-1:0]         o_dst_addr,
    output logic [DATA_WIDTH-1:0]                o_dst_weight,
    output logic                                 o_sync_busy,
    output logic                                 o_sync_done,
    output logic [$clog2(SYNC_PERIOD + 1)-1:0]   o_step_count
);

    localparam int CNT_WIDTH  = $clog2(SYNC_PERIOD + 1);
    localparam int L1 = layer1_size(NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1);
    localparam int L2 = layer2_size(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2);
    localparam int L3 = layer3_size(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
    localparam int TOTAL = L1 + L2 + L3;
    localparam int RECV_WIDTH = $clog2(TOTAL + 1);

    localparam logic [WEIGHT_ADDR_WIDTH-1:0] L1_LAST = WEIGHT_ADDR_WIDTH'(L1 - 1);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] L2_LAST = WEIGHT_ADDR_WIDTH'(L2 - 1);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] L3_LAST = WEIGHT_ADDR_WIDTH'(L3 - 1);
    localparam logic [LAYER_WIDTH-1:0] CODE_H1  = LAYER_WIDTH'(LAYER_H1);
    localparam logic [LAYER_WIDTH-1:0] CODE_H2  = LAYER_WIDTH'(LAYER_H2);
    localparam logic [LAYER_WIDTH-1:0] CODE_OUT = LAYER_WIDTH'(LAYER_OUT);
    localparam logic [RECV_WIDTH-1:0]  RECV_ALL = RECV_WIDTH'(TOTAL);

    sync_state_t                  state;
    logic                         pending;
    logic                         start_copy;
    logic                         accept;
    logic                         last_of_layer;
    logic [WEIGHT_ADDR_WIDTH-1:0] last_addr;
    logic [RECV_WIDTH-1:0]        recv_count;
    logic [CNT_WIDTH-1:0]         step_count;

    sync_step_counter #(
        .SYNC_PERIOD (SYNC_PERIOD),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_step_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .step_valid    (i_step_valid),
        .force_sync    (i_force_sync),
        .clear_pending (start_copy),
        .step_count    (step_count),
        .pending       (pending)
    );

    assign o_step_count = step_count;

    // Feed-forward busy only gates the start of a copy, never a copy already running.
    assign start_copy = pending && !i_fw_busy
                     && ((state == ST_IDLE) || (state == ST_WAIT_FW) || (state == ST_DONE));
    assign accept     = i_src_valid && ((state == ST_ISSUE) || (state == ST_DRAIN));

    always_comb begin
        last_addr = L3_LAST;
        if (o_src_rd_layer == CODE_H1) begin
            last_addr = L1_LAST;
        end else if (o_src_rd_layer == CODE_H2) begin
            last_addr = L2_LAST;
        end
    end

    assign last_of_layer = (o_src_rd_addr == last_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            o_src_rd_valid <= 1'b0;
            o_src_rd_layer <= '0;
            o_src_rd_addr  <= '0;
            o_sync_busy    <= 1'b0;
            o_sync_done    <= 1'b0;
            recv_count     <= '0;
        end else begin
            o_sync_done <= 1'b0;
            if (accept) begin
                recv_count <= recv_count + 1'b1;
            end
            case (state)
                ST_IDLE, ST_WAIT_FW, ST_DONE: begin
                    if (start_copy) begin
                        state          <= ST_ISSUE;
                        o_src_rd_valid <= 1'b1;
                        o_src_rd_layer <= CODE_H1;
                        o_src_rd_addr  <= '0;
                        o_sync_busy    <= 1'b1;
                        recv_count     <= '0;
                    end else if (pending) begin
                        state       <= ST_WAIT_FW;
                        o_sync_busy <= 1'b1;
                    end else begin
                        state       <= ST_IDLE;
                        o_sync_busy <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (last_of_layer && (o_src_rd_layer == CODE_OUT)) begin
                        state          <= ST_DRAIN;
                        o_src_rd_valid <= 1'b0;
                        o_src_rd_layer <= '0;
                        o_src_rd_addr  <= '0;
                    end else if (last_of_layer) begin
                        o_src_rd_layer <= o_src_rd_layer + 1'b1;
                        o_src_rd_addr  <= '0;
                    end else begin
                        o_src_rd_addr <= o_src_rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (recv_count == RECV_ALL) begin
                        state       <= ST_DONE;
                        o_sync_done <= 1'b1;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    o_src_rd_valid <= 1'b0;
                    o_sync_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Returned words are forwarded untouched; only the strobe depends on the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dst_wr_valid <= 1'b0;
            o_dst_layer    <= '0;
            o_dst_addr     <= '0;
            o_dst_weight   <= '0;
        end else begin
            o_dst_wr_valid <= accept;
            if (accept) begin
                o_dst_layer  <= i_src_layer;
                o_dst_addr   <= i_src_addr;
                o_dst_weight <= i_src_weight;
            end
        end
    end

endmodule

// File: tb/tb_target_sync_ctrl.sv
// Randomised self-checking bench for target_sync_ctrl with a small network
// (IN=2, H1=4, H2=4, OUT=3) and a latency-2 online weight memory model.
module tb_target_sync_ctrl;

    localparam int DW = 32;
    localparam int LW = 2;
    localparam int AW = 11;
    localparam int N_IN = 2;
    localparam int N_H1 = 4;
    localparam int N_H2 = 4;
    localparam int N_OUT = 3;
    localparam int PERIOD = 5;
    localparam int CW = $clog2(PERIOD + 1);
    localparam int L1 = N_H1 * (N_IN + 1);
    localparam int L2 = N_H2 * (N_H1 + 1);
    localparam int L3 = N_OUT * (N_H2 + 1);
    localparam int TOTAL = L1 + L2 + L3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_step_valid = 1'b0;
    logic i_force_sync = 1'b0;
    logic i_fw_busy = 1'b0;
    logic o_src_rd_valid;
    logic [LW-1:0] o_src_rd_layer;
    logic [AW-1:0] o_src_rd_addr;
    logic i_src_valid = 1'b0;
    logic [LW-1:0] i_src_layer = '0;
    logic [AW-1:0] i_src_addr = '0;
    logic [DW-1:0] i_src_weight = '0;
    logic o_dst_wr_valid;
    logic [LW-1:0] o_dst_layer;
    logic [AW-1:0] o_dst_addr;
    logic [DW-1:0] o_dst_weight;
    logic o_sync_busy;
    logic o_sync_done;
    logic [CW-1:0] o_step_count;

    int checks = 0;
    int failures = 0;

    initial forever #5 clk = ~clk;

    target_sync_ctrl #(
        .DATA_WIDTH                    (DW),
        .LAYER_WIDTH                   (LW),
        .NUMBER_OF_INPUT_NODE          (N_IN),
        .NUMBER_OF_HIDDEN_NODE_LAYER_1 (N_H1),
        .NUMBER_OF_HIDDEN_NODE_LAYER_2 (N_H2),
        .NUMBER_OF_OUTPUT_NODE         (N_OUT),
        .SYNC_PERIOD                   (PERIOD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_step_valid   (i_step_valid),
        .i_force_sync   (i_force_sync),
        .i_fw_busy      (i_fw_busy),
        .o_src_rd_valid (o_src_rd_valid),
        .o_src_rd_layer (o_src_rd_layer),
        .o_src_rd_addr  (o_src_rd_addr),
        .i_src_valid    (i_src_valid),
        .i_src_layer    (i_src_layer),
        .i_src_addr     (i_src_addr),
        .i_src_weight   (i_src_weight),
        .o_dst_wr_valid (o_dst_wr_valid),
        .o_dst_layer    (o_dst_layer),
        .o_dst_addr     (o_dst_addr),
        .o_dst_weight   (o_dst_weight),
        .o_sync_busy    (o_sync_busy),
        .o_sync_done    (o_sync_done),
        .o_step_count   (o_step_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] weight_of(input int layer, input int addr);
        return (32'(layer * 2048 + addr) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Flat copy index -> (layer, address) of the weight read at that position.
    function automatic int layer_at(input int idx);
        if (idx < L1) return 1;
        if (idx < L1 + L2) return 2;
        return 3;
    endfunction

    function automatic int addr_at(input int idx);
        if (idx < L1) return idx;
        if (idx < L1 + L2) return idx - L1;
        return idx - L1 - L2;
    endfunction

    // Online weight memory: data for a request appears two cycles later.
    logic spurious = 1'b0;
    logic d0v = 1'b0, d1v = 1'b0;
    logic [LW-1:0] d0l = '0, d1l = '0;
    logic [AW-1:0] d0a = '0, d1a = '0;

    always @(negedge clk) begin
        i_src_valid  = d1v | spurious;
        i_src_layer  = d1v ? d1l : LW'(3);
        i_src_addr   = d1v ? d1a : AW'(5);
        i_src_weight = weight_of(int'(i_src_layer), int'(i_src_addr));
        d1v = d0v; d1l = d0l; d1a = d0a;
        d0v = o_src_rd_valid; d0l = o_src_rd_layer; d0a = o_src_rd_addr;
    end

    // Behavioural model: copy progress tracked as counts of reads issued and words received.
    int m_count = 0, m_issued = 0, m_recv = 0;
    bit m_pending = 0, m_active = 0, m_waiting = 0, m_done = 0;
    bit m_trig, m_accept, m_start, exp_rd;
    bit e_wr = 0;
    logic [LW-1:0] e_layer = '0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_weight = '0;
    int cyc = 0, rd_total = 0, wr_total = 0, done_total = 0;
    int last_rd_cyc = 0, last_wr_cyc = 0, last_done_cyc = 0;
    logic [12:0] rd_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_count = 0; m_issued = 0; m_recv = 0;
            m_pending = 0; m_active = 0; m_waiting = 0; m_done = 0; e_wr = 0;
        end else begin
            m_trig = i_force_sync || (i_step_valid && m_count == PERIOD - 1);
            if (i_force_sync) m_count = 0;
            else if (i_step_valid) m_count = (m_count + 1) % PERIOD;
            m_accept = i_src_valid && m_active;
            e_wr = m_accept;
            e_layer = i_src_layer; e_addr = i_src_addr; e_weight = i_src_weight;
            m_start = 0;
            if (m_active) begin
                if (m_issued < TOTAL) m_issued++;
                else if (m_recv == TOTAL) begin m_active = 0; m_done = 1; end
            end else begin
                m_done = 0;
                if (m_pending && !i_fw_busy) m_start = 1;
                else m_waiting = m_pending;
            end
            if (m_accept) m_recv++;
            if (m_start) begin m_active = 1; m_issued = 0; m_recv = 0; m_waiting = 0; end
            m_pending = (m_pending && !m_start) || m_trig;
        end
        #3;
        cyc++;
        exp_rd = m_active && (m_issued < TOTAL);
        checkOutput("rd_valid", 32'(o_src_rd_valid), 32'(exp_rd));
        if (exp_rd) begin
            checkOutput("rd_layer", 32'(o_src_rd_layer), 32'(layer_at(m_issued)));
            checkOutput("rd_addr", 32'(o_src_rd_addr), 32'(addr_at(m_issued)));
        end
        checkOutput("wr_valid", 32'(o_dst_wr_valid), 32'(e_wr));
        if (e_wr) begin
            checkOutput("wr_layer", 32'(o_dst_layer), 32'(e_layer));
            checkOutput("wr_addr", 32'(o_dst_addr), 32'(e_addr));
            checkOutput("wr_weight", o_dst_weight, e_weight);
        end
        checkOutput("sync_busy", 32'(o_sync_busy), 32'(m_active || m_waiting || m_done));
        checkOutput("sync_done", 32'(o_sync_done), 32'(m_done));
        checkOutput("step_count", 32'(o_step_count), 32'(m_count));
        if (o_src_rd_valid) begin
            rd_q.push_back({o_src_rd_layer, o_src_rd_addr});
            rd_total++; last_rd_cyc = cyc;
        end
        if (o_dst_wr_valid) begin wr_total++; last_wr_cyc = cyc; end
        if (o_sync_done) begin done_total++; last_done_cyc = cyc; end
    end

    task automatic applyStimulus(input logic force_pulse, input logic step_pulse);
        @(negedge clk);
        i_force_sync = force_pulse;
        i_step_valid = step_pulse;
        @(negedge clk);
        i_force_sync = 1'b0;
        i_step_valid = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n = 0;
        while (done_total < target && n < budget) begin @(negedge clk); n++; end
        checkOutput("wait_done", 32'(done_total >= target), 32'd1);
    endtask

    task automatic waitRead(input int budget);
        int n = 0;
        while (!o_src_rd_valid && n < budget) begin @(negedge clk); n++; end
        checkOutput("wait_read", 32'(o_src_rd_valid), 32'd1);
    endtask

    int r0, w0, d0;

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_rd_valid", 32'(o_src_rd_valid), 32'd0);
        checkOutput("reset_busy", 32'(o_sync_busy), 32'd0);
        checkOutput("reset_wr_valid", 32'(o_dst_wr_valid), 32'd0);
        rst_n = 1'b1;

        // Forced sync: full read sequence, matching writes, one done pulse.
        applyStimulus(1'b1, 1'b0);
        waitDone(1, 200);
        checkOutput("t1_reads", 32'(rd_total), 32'd47);
        checkOutput("t1_writes", 32'(wr_total), 32'd47);
        checkOutput("t1_done", 32'(done_total), 32'd1);
        checkOutput("seq_0", 32'(rd_q[0]), 32'({2'd1, 11'd0}));
        checkOutput("seq_11", 32'(rd_q[11]), 32'({2'd1, 11'd11}));
        checkOutput("seq_12", 32'(rd_q[12]), 32'({2'd2, 11'd0}));
        checkOutput("seq_31", 32'(rd_q[31]), 32'({2'd2, 11'd19}));
        checkOutput("seq_32", 32'(rd_q[32]), 32'({2'd3, 11'd0}));
        checkOutput("seq_46", 32'(rd_q[46]), 32'({2'd3, 11'd14}));
        checkOutput("done_after_write", 32'(last_done_cyc - last_wr_cyc), 32'd1);
        checkOutput("done_after_read", 32'(last_done_cyc - last_rd_cyc), 32'd4);

        // Four steps must not sync; the fifth wraps the count and syncs.
        repeat (4) applyStimulus(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("four_steps_count", 32'(o_step_count), 32'd4);
        checkOutput("four_steps_no_read", 32'(rd_total), 32'd47);
        applyStimulus(1'b0, 1'b1);
        checkOutput("fifth_step_count", 32'(o_step_count), 32'd0);
        waitDone(2, 200);
        checkOutput("t2_reads", 32'(rd_total), 32'd94);

        // Feed-forward busy holds the copy in WAIT_FW.
        r0 = rd_total;
        i_fw_busy = 1'b1;
        applyStimulus(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("wait_busy", 32'(o_sync_busy), 32'd1);
        checkOutput("wait_no_read", 32'(rd_total - r0), 32'd0);
        i_fw_busy = 1'b0;
        @(negedge clk);
        checkOutput("wait_first_read", 32'(o_src_rd_valid), 32'd1);
        checkOutput("wait_first_addr", 32'({o_src_rd_layer, o_src_rd_addr}), 32'({2'd1, 11'd0}));
        waitDone(3, 200);

        // Force plus a full step period during ISSUE collapse into one extra sync.
        w0 = wr_total; d0 = done_total;
        applyStimulus(1'b1, 1'b0);
        waitRead(20);
        applyStimulus(1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b1);
        waitDone(d0 + 2, 400);
        repeat (60) @(negedge clk);
        checkOutput("collapse_done", 32'(done_total - d0), 32'd2);
        checkOutput("collapse_writes", 32'(wr_total - w0), 32'd94);

        // Returns outside a copy are ignored.
        w0 = wr_total;
        @(negedge clk) spurious = 1'b1;
        repeat (6) @(negedge clk);
        spurious = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("spurious_no_write", 32'(wr_total - w0), 32'd0);

        // Reset mid-copy abandons it without a done pulse; the next force restarts cleanly.
        r0 = rd_total; d0 = done_total;
        applyStimulus(1'b1, 1'b0);
        for (int n = 0; n < 100 && rd_total < r0 + 20; n++) @(negedge clk);
        checkOutput("reached_read_20", 32'(rd_total - r0 >= 20), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rd_valid", 32'(o_src_rd_valid), 32'd0);
        checkOutput("rst_rd_addr", 32'({o_src_rd_layer, o_src_rd_addr}), 32'd0);
        checkOutput("rst_wr_valid", 32'(o_dst_wr_valid), 32'd0);
        checkOutput("rst_busy", 32'(o_sync_busy), 32'd0);
        checkOutput("rst_done", 32'(o_sync_done), 32'd0);
        checkOutput("rst_step_count", 32'(o_step_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rst_no_done", 32'(done_total - d0), 32'd0);
        applyStimulus(1'b1, 1'b0);
        waitRead(20);
        checkOutput("restart_addr", 32'({o_src_rd_layer, o_src_rd_addr}), 32'({2'd1, 11'd0}));
        waitDone(d0 + 1, 200);

        // Random steps, forces and feed-forward activity against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            i_step_valid = ($urandom_range(0, 9) == 0);
            i_force_sync = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) i_fw_busy = ~i_fw_busy;
        end
        @(negedge clk);
        i_step_valid = 1'b0;
        i_force_sync = 1'b0;
        i_fw_busy = 1'b0;
        for (int n = 0; n < 400 && o_sync_busy; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        checkOutput("final_idle", 32'(o_sync_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
